imem_dmem_arbiter: RTL and testbench

Shares one single-port, handshaked memory between the CPU's instruction-fetch port and its data port. The block sits between the pipelined CPU core and the unified memory. It serialises each cycle's data access and instruction fetch into memory transactions, and freezes the core with `cpu_hold` until both complete. It also counts hold cycles for performance debug.

---
 rtl/imem_dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port handshaked memory between the
// core's data port and its instruction-fetch port. Each core cycle is turned
// into an optional data transaction followed by a fetch transaction, and the
// core is frozen with cpu_hold until both have completed.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | capture the core's request, choose data-first or fetch-only
// D_REQ  | data request on the bus, waiting for m_ready
// D_WAIT | data request accepted, waiting for m_rvalid (read data / store ack)
// I_REQ  | fetch request on the bus, waiting for m_ready
// I_WAIT | fetch accepted, waiting for m_rvalid
// DONE   | both results available, core released for one cycle
module imem_dmem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_iaddr,
  input  logic [31:0] cpu_daddr,
  input  logic [31:0] cpu_dwdata,
  input  logic [3:0]  cpu_we,
  input  logic        cpu_dre,
  output logic [31:0] cpu_idata,
  output logic [31:0] cpu_drdata,
  output logic        cpu_hold,
  output logic        m_req,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_we,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic [31:0] stall_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_REQ  = 3'd1,
    D_WAIT = 3'd2,
    I_REQ  = 3'd3,
    I_WAIT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      state;

  // Fetch address is needed after the data access finishes; the data-side
  // address, write data and enables live in the registered bus outputs while
  // D_REQ is active, so only the fetch address and store enables are kept here.
  logic [31:0] iaddr_q;
  logic [3:0]  we_q;

  // Sequencer: state, registered bus/core outputs and the hold-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      iaddr_q    <= '0;
      we_q       <= '0;
      cpu_idata  <= '0;
      cpu_drdata <= '0;
      cpu_hold   <= 1'b1;
      m_req      <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_we       <= '0;
      stall_cnt  <= '0;
    end else begin
      // cpu_hold is registered and always equals (state != DONE).
      if (cpu_hold) begin
        stall_cnt <= stall_cnt + 32'd1;
      end

      case (state)
        IDLE: begin
          iaddr_q  <= cpu_iaddr;
          we_q     <= cpu_we;
          cpu_hold <= 1'b1;
          m_req    <= 1'b1;
          if (cpu_dre || (cpu_we != 4'b0000)) begin
            state   <= D_REQ;
            m_addr  <= cpu_daddr & 32'hFFFF_FFFC;
            m_we    <= cpu_we;
            m_wdata <= cpu_dwdata;
          end else begin
            state   <= I_REQ;
            m_addr  <= cpu_iaddr & 32'hFFFF_FFFC;
            m_we    <= 4'b0000;
            m_wdata <= '0;
          end
        end

        D_REQ: begin
          // A same-cycle m_rvalid here belongs to nothing we issued; only
          // the acceptance matters.
          if (m_ready) begin
            state   <= D_WAIT;
            m_req   <= 1'b0;
            m_addr  <= '0;
            m_we    <= 4'b0000;
            m_wdata <= '0;
          end
        end

        D_WAIT: begin
          // Stores also wait here: m_rvalid is the write acknowledge.
          if (m_rvalid) begin
            if (we_q == 4'b0000) begin
              cpu_drdata <= m_rdata;
            end
            state   <= I_REQ;
            m_req   <= 1'b1;
            m_addr  <= iaddr_q & 32'hFFFF_FFFC;
            m_we    <= 4'b0000;
            m_wdata <= '0;
          end
        end

        I_REQ: begin
          if (m_ready) begin
            state   <= I_WAIT;
            m_req   <= 1'b0;
            m_addr  <= '0;
            m_we    <= 4'b0000;
            m_wdata <= '0;
          end
        end

        I_WAIT: begin
          if (m_rvalid) begin
            cpu_idata <= m_rdata;
            state     <= DONE;
            cpu_hold  <= 1'b0;
          end
        end

        DONE: begin
          state    <= IDLE;
          cpu_hold <= 1'b1;
        end

        default: begin
          state    <= IDLE;
          cpu_hold <= 1'b1;
          m_req    <= 1'b0;
          m_addr   <= '0;
          m_we     <= 4'b0000;
          m_wdata  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Testbench for imem_dmem_arbiter: a scoreboard of expected memory requests
// is filled when a core request is applied and drained as the arbiter puts
// requests on the bus; a small memory responder with programmable ready and
// response delays serves them.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_iaddr, cpu_daddr, cpu_dwdata;
  logic [3:0]  cpu_we;
  logic        cpu_dre;
  logic [31:0] cpu_idata, cpu_drdata;
  logic        cpu_hold;
  logic        m_req;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_we;
  logic        m_ready, m_rvalid;
  logic [31:0] m_rdata;
  logic [31:0] stall_cnt;

  imem_dmem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_iaddr  (cpu_iaddr),
    .cpu_daddr  (cpu_daddr),
    .cpu_dwdata (cpu_dwdata),
    .cpu_we     (cpu_we),
    .cpu_dre    (cpu_dre),
    .cpu_idata  (cpu_idata),
    .cpu_drdata (cpu_drdata),
    .cpu_hold   (cpu_hold),
    .m_req      (m_req),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_we       (m_we),
    .m_ready    (m_ready),
    .m_rvalid   (m_rvalid),
    .m_rdata    (m_rdata),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_idata, exp_drdata, exp_stall;

  // One core cycle: apply request, serve data then fetch, check at DONE.
  // Called at a negedge just before the arbiter's IDLE cycle is sampled.
  // pre = 1 when the IDLE cycle is the current one (right after reset).
  task automatic run_txn(input logic [31:0] iaddr, input logic [31:0] daddr,
                         input logic [31:0] dwdata, input logic [3:0] we,
                         input logic dre, input int rd0, input int vd0,
                         input int rd1, input int vd1, input logic [31:0] dd,
                         input logic [31:0] id, input int pre, input bit spur);
    req_t        e, got;
    int          rdly[2], vdly[2];
    logic [31:0] rdat[2];
    int          k, phase, rwait, vwait, hold_cnt, exp_hold;
    bit          seen, done, is_d;
    cpu_iaddr  = iaddr;
    cpu_daddr  = daddr;
    cpu_dwdata = dwdata;
    cpu_we     = we;
    cpu_dre    = dre;
    is_d = dre || (we != 4'b0000);
    if (is_d) begin
      e.addr = daddr & 32'hFFFF_FFFC; e.we = we; e.wdata = dwdata;
      exp_q.push_back(e);
    end
    e.addr = iaddr & 32'hFFFF_FFFC; e.we = 4'b0000; e.wdata = 32'h0;
    exp_q.push_back(e);
    exp_hold = 3 + rd1 + vd1 + (is_d ? (2 + rd0 + vd0) : 0);
    if (is_d && we == 4'b0000) exp_drdata = dd;
    exp_idata = id;
    exp_stall = exp_stall + 32'(exp_hold);
    rdly[0] = rd0; rdly[1] = rd1; vdly[0] = vd0; vdly[1] = vd1;
    rdat[0] = dd;  rdat[1] = id;
    k = is_d ? 0 : 1;
    phase = 0; rwait = 0; vwait = 0; seen = 0; done = 0; hold_cnt = pre;
    got.addr = '0; got.we = '0; got.wdata = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
      if (!cpu_hold) begin
        done = 1;
      end else begin
        hold_cnt++;
        if (phase == 0) begin
          if (m_req) begin
            if (!seen) begin
              checks++;
              if (exp_q.size() == 0 || k > 1) begin
                errors++;
                $display("FAIL unexpected_req got addr %h we %h", m_addr, m_we);
              end else begin
                e = exp_q.pop_front();
                if (m_addr !== e.addr || m_we !== e.we || m_wdata !== e.wdata) begin
                  errors++;
                  $display("FAIL req got %h/%h/%h want %h/%h/%h",
                           m_addr, m_we, m_wdata, e.addr, e.we, e.wdata);
                end
              end
              got.addr = m_addr; got.we = m_we; got.wdata = m_wdata;
              seen = 1;
            end else begin
              checks++;
              if (m_addr !== got.addr || m_we !== got.we || m_wdata !== got.wdata) begin
                errors++;
                $display("FAIL req_stable got %h/%h/%h want %h/%h/%h",
                         m_addr, m_we, m_wdata, got.addr, got.we, got.wdata);
              end
            end
            if (k <= 1) begin
              if (rwait == rdly[k]) begin
                m_ready = 1'b1;
                if (spur) begin m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0; end
                phase = 1; seen = 0; rwait = 0;
              end else begin
                rwait++;
              end
            end
          end else if (seen) begin
            checks++; errors++;
            $display("FAIL req_drop got m_req 0 want 1");
            seen = 0;
          end
        end else begin
          checks++;
          if (m_req !== 1'b0 || m_addr !== 32'h0 || m_we !== 4'h0 || m_wdata !== 32'h0) begin
            errors++;
            $display("FAIL bus_idle got %b/%h/%h/%h want 0/0/0/0", m_req, m_addr, m_we, m_wdata);
          end
          if (vwait == vdly[k]) begin
            m_rvalid = 1'b1; m_rdata = rdat[k];
            phase = 0; vwait = 0; k++;
          end else begin
            vwait++;
          end
        end
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout got no DONE within 200 cycles");
    end
    checks++;
    if (hold_cnt != exp_hold) begin
      errors++; $display("FAIL hold_cycles got %0d want %0d", hold_cnt, exp_hold);
    end
    checks++;
    if (cpu_idata !== exp_idata) begin
      errors++; $display("FAIL idata got %h want %h", cpu_idata, exp_idata);
    end
    checks++;
    if (cpu_drdata !== exp_drdata) begin
      errors++; $display("FAIL drdata got %h want %h", cpu_drdata, exp_drdata);
    end
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++; $display("FAIL stall_cnt got %h want %h", stall_cnt, exp_stall);
    end
    checks++;
    if (exp_q.size() != 0 || m_req !== 1'b0) begin
      errors++;
      $display("FAIL pending_reqs got %0d/%b want 0/0", exp_q.size(), m_req);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_iaddr = '0; cpu_daddr = '0; cpu_dwdata = '0; cpu_we = '0; cpu_dre = 1'b0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_hold got %b want 1", cpu_hold); end
    checks++;
    if (m_req !== 1'b0 || m_addr !== 32'h0 || m_we !== 4'h0 || m_wdata !== 32'h0) begin
      errors++; $display("FAIL rst_bus got %b/%h/%h/%h want 0/0/0/0", m_req, m_addr, m_we, m_wdata);
    end
    checks++;
    if (cpu_idata !== 32'h0 || cpu_drdata !== 32'h0) begin
      errors++; $display("FAIL rst_data got %h/%h want 0/0", cpu_idata, cpu_drdata);
    end
    checks++;
    if (stall_cnt !== 32'h0) begin errors++; $display("FAIL rst_stall got %h want 0", stall_cnt); end
    exp_idata = '0; exp_drdata = '0; exp_stall = '0;
    reset = 1'b0;
  endtask

  // Fetch only, immediately after reset: stall_cnt ends at 3.
  task automatic test_fetch();
    run_txn(32'h100, 32'h0, 32'h0, 4'b0000, 1'b0, 0, 0, 0, 0, 32'h0, 32'h0050_0093, 1, 0);
  endtask

  task automatic test_load();
    run_txn(32'h104, 32'h203, 32'h0, 4'b0000, 1'b1, 0, 0, 0, 0,
            32'hDEAD_BEEF, 32'h0000_0013, 0, 0);
  endtask

  task automatic test_store();
    run_txn(32'h108, 32'h40, 32'h0000_ABCD, 4'b0011, 1'b0, 0, 0, 0, 0,
            32'h5555_5555, 32'h0000_0017, 0, 0);
  endtask

  task automatic test_backpressure();
    run_txn(32'h10C, 32'h0, 32'h0, 4'b0000, 1'b0, 0, 0, 3, 0, 32'h0, 32'h1234_5678, 0, 0);
    run_txn(32'h110, 32'h88, 32'h0, 4'b0000, 1'b1, 2, 1, 1, 2,
            32'hCAFE_0001, 32'hCAFE_0002, 0, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      int          kind;
      logic [3:0]  we;
      kind = $urandom_range(0, 2);
      we   = (kind == 2) ? 4'($urandom_range(1, 15)) : 4'b0000;
      run_txn($urandom, $urandom, $urandom, we, (kind == 1),
              $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom, $urandom, 0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    cpu_iaddr = 32'h200; cpu_daddr = 32'h300; cpu_dwdata = 32'h0; cpu_we = 4'b0000; cpu_dre = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h300) begin
      errors++; $display("FAIL mid_dreq got %b/%h want 1/00000300", m_req, m_addr);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (m_req !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL mid_rst_bus got %b/%b want 0/1", m_req, cpu_hold);
    end
    checks++;
    if (cpu_drdata !== 32'h0 || cpu_idata !== 32'h0 || stall_cnt !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst_vals got %h/%h/%h want 0/0/0", cpu_drdata, cpu_idata, stall_cnt);
    end
    exp_idata = '0; exp_drdata = '0; exp_stall = '0;
    reset = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
    run_txn(32'h114, 32'h404, 32'h1234_5678, 4'b1111, 1'b0, 0, 0, 0, 0,
            32'h0, 32'h0000_0033, 1, 0);
  endtask

  task automatic test_wrap();
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    exp_stall = 32'hFFFF_FFFE;
    run_txn(32'h118, 32'h0, 32'h0, 4'b0000, 1'b0, 0, 0, 0, 0, 32'h0, 32'h0000_0073, 0, 0);
    checks++;
    if (stall_cnt !== 32'h1) begin
      errors++; $display("FAIL wrap got %h want 00000001", stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "global timeout");
  end

endmodule
